// File: rtl/conv_pkg.sv
// Shared constants, bank selects and FSM states for the CONV host-side responder.
package conv_pkg;

    localparam int DW        = 20;
    localparam int AW        = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP0,
        ST_DUMP1
    } state_e;

endpackage

// File: rtl/conv_host_ram.sv
// Register-file memory: one synchronous write port, one asynchronous read port.
module conv_host_ram #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees pre-write contents when the same address is written this edge.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_host_port.sv
// Host responder for CONV: loads the image, serves CONV fetches and layer
// memory accesses, then streams Layer 0 and Layer 1 results downstream.
module conv_host_port
    import conv_pkg::*;
#(
    parameter int DW        = conv_pkg::DW,
    parameter int AW        = conv_pkg::AW,
    parameter int IMG_DEPTH = conv_pkg::IMG_DEPTH,
    parameter int L1_DEPTH  = conv_pkg::L1_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_layer,
    output logic          m_last,
    input  logic          m_ready,
    output logic          done
);

    localparam int L1_AW = $clog2(L1_DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [DW-1:0] cdata_rd_q, cdata_rd_d;

    logic          img_we, l0_we, l1_we;
    logic [AW-1:0] l0_raddr;
    logic [L1_AW-1:0] l1_raddr;
    logic [DW-1:0] img_rdata, l0_rdata, l1_rdata;

    // Layer memories share one read port between CONV reads (RUN) and readout (DUMP).
    assign l0_raddr = (state_q == ST_RUN) ? caddr_rd : cnt_q;
    assign l1_raddr = (state_q == ST_RUN) ? caddr_rd[L1_AW-1:0] : cnt_q[L1_AW-1:0];

    conv_host_ram #(.DW(DW), .AW(AW), .DEPTH(IMG_DEPTH)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (cnt_q),
        .wdata (s_data),
        .raddr (iaddr),
        .rdata (img_rdata)
    );

    conv_host_ram #(.DW(DW), .AW(AW), .DEPTH(IMG_DEPTH)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (l0_raddr),
        .rdata (l0_rdata)
    );

    conv_host_ram #(.DW(DW), .AW(L1_AW), .DEPTH(L1_DEPTH)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr (l1_raddr),
        .rdata (l1_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            cdata_rd_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            cdata_rd_q <= cdata_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        s_ready = 1'b0;
        ready   = 1'b0;
        m_valid = 1'b0;
        m_layer = 1'b0;
        m_last  = 1'b0;
        img_we  = 1'b0;
        l0_we   = 1'b0;
        l1_we   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // Held low while reset is asserted so no word is taken mid-reset.
                s_ready = !reset;
                if (s_valid && !reset) begin
                    img_we = 1'b1;
                    if (cnt_q == AW'(IMG_DEPTH - 1)) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            ST_START: begin
                ready = 1'b1;
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                l0_we = cwr && (csel == CSEL_L0);
                l1_we = cwr && (csel == CSEL_L1);
                if (!busy) begin
                    state_d = ST_DUMP0;
                end
            end
            ST_DUMP0: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (cnt_q == AW'(IMG_DEPTH - 1)) begin
                        state_d = ST_DUMP1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            ST_DUMP1: begin
                m_valid = 1'b1;
                m_layer = 1'b1;
                m_last  = (cnt_q == AW'(L1_DEPTH - 1));
                if (m_ready) begin
                    if (m_last) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        cdata_rd_d = cdata_rd_q;
        if (state_q == ST_RUN && crd) begin
            case (csel)
                CSEL_L0: cdata_rd_d = l0_rdata;
                CSEL_L1: cdata_rd_d = l1_rdata;
                default: cdata_rd_d = '0;
            endcase
        end
    end

    assign cdata_rd = cdata_rd_d;
    assign idata    = (state_q == ST_START || state_q == ST_RUN) ? img_rdata : '0;
    assign m_data   = (state_q == ST_DUMP0) ? l0_rdata :
                      (state_q == ST_DUMP1) ? l1_rdata : '0;
    assign done     = done_q;

endmodule

// File: doc/conv_host_port.md
# conv_host_port

Host-side responder for the CONV accelerator interface in the ICC2018 CNN flow. Accepts a 64x64 image stream from the system, releases CONV with the `ready`/`busy` handshake, and serves CONV's image-fetch (`iaddr`/`idata`) and layer-memory (`crd`/`cwr`/`csel`) accesses from on-chip storage. After CONV drops `busy`, it streams the Layer 0 result (4096 words) and then the Layer 1 result (1024 words) out to the system. This is the synthesizable counterpart of the memory model the CONV bench uses.

## Interface
- `DW`, 20: pixel/result word width
- `AW`, 12: address width for image and Layer 0
- `IMG_DEPTH`, 4096: image and Layer 0 word count
- `L1_DEPTH`, 1024: Layer 1 word count
- One clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `s_valid` in 1: image word valid
- `s_data` in DW: image word, raster order
- `s_ready` out 1: image word accepted when `s_valid & s_ready`
- `ready` out 1: to CONV, image available
- `busy` in 1: from CONV
- `iaddr` in AW: CONV image address
- `idata` out DW: image word at `iaddr`
- `cwr` in 1: CONV write strobe
- `caddr_wr` in AW: write address
- `cdata_wr` in DW: write data
- `crd` in 1: CONV read strobe
- `caddr_rd` in AW: read address
- `cdata_rd` out DW: read data
- `csel` in 3: bank select, 3'b001 = L0, 3'b011 = L1
- `m_valid` out 1: result word valid
- `m_data` out DW: result word
- `m_layer` out 1: 0 = L0 word, 1 = L1 word
- `m_last` out 1: final L1 word
- `m_ready` in 1: downstream accept
- `done` out 1: one-cycle pulse after the final result word is accepted

## Operation
- The FSM has five states: LOAD, START, RUN, DUMP0, DUMP1.
- **LOAD**
  - `s_ready`=1.
  - Each accepted word is written to `img[cnt]` and `cnt` increments.
  - On acceptance with `cnt`=IMG_DEPTH-1: go to START and clear `cnt`.
- **START**
  - `ready`=1.
  - When `busy`=1 is sampled: go to RUN. `ready` falls on that same edge.
- **RUN**
  - `idata` = `img[iaddr]`.
  - `cwr`=1 with csel 001 writes `l0[caddr_wr]`; csel 011 writes `l1[caddr_wr[9:0]]`; any other csel is ignored.
  - `crd`=1 with csel 001 reads `l0`; csel 011 reads `l1`; any other csel loads 0.
  - When `busy`=0 is sampled: go to DUMP0.
- **DUMP0**
  - `m_valid`=1, `m_layer`=0, `m_data`=`l0[cnt]`.
  - On handshake, increment `cnt`.
  - On handshake at IMG_DEPTH-1: go to DUMP1 and clear `cnt`.
- **DUMP1**
  - Same as DUMP0, but reads `l1` with `m_layer`=1.
  - `m_last`=1 when `cnt`=L1_DEPTH-1.
  - On the final handshake: pulse `done`, go to LOAD.
- `m_data`, `m_layer` and `m_last` stay stable while `m_valid & !m_ready`.
- CONV writes and reads outside RUN are ignored, and `cdata_rd` holds its value.
- `idata` is 0 outside START/RUN.
- Reset mid-operation: the FSM returns to LOAD and `cnt` clears. Memory contents are not cleared.

## Timing
- Reset values:
  - `s_ready`=0 during reset, 1 the cycle after.
  - `ready`=0, `m_valid`=0, `m_layer`=0, `m_last`=0, `done`=0.
  - `idata`=0, `cdata_rd`=0.
- `idata`: same-cycle asynchronous read of `img[iaddr]`, valid before the next rising edge. CONV samples it in the cycle it drives `iaddr`.
- `cdata_rd`: same-cycle asynchronous read while `crd`=1; it holds its last value when `crd`=0. CONV samples it at the next rising edge.
- `cwr` writes commit at the rising edge where `cwr`=1.
- A simultaneous `cwr` and `crd` to the same address and bank returns the old data.
- `ready` rises in the first START cycle. It falls at the edge that samples `busy`=1, so it is high for at least 1 cycle.
- Latency:
  - DUMP0 is entered 1 cycle after `busy` falls, and the first `m_valid` appears in that cycle.
  - With `m_ready` held high, throughput is 1 word/cycle: 5120 cycles from the first result word to `done`.
- Stray `busy`=1 in LOAD is ignored.

## Structure
- Shared package `conv_pkg` holds:
  - `CSEL_L0`=3'b001, `CSEL_L1`=3'b011
  - DW, AW, IMG_DEPTH, L1_DEPTH
  - the state enum
- Sub-module `conv_host_ram`: a parameterized single-write, async-read register-file memory, instantiated three times (img, l0, l1).
- The FSM, counter and handshake logic sit in the top module.

## Test plan
- **Load and handshake:** stream 4096 words (`s_data`=address), with `s_valid` dropped every 7th cycle -> `s_ready` falls after word 4095 and `ready`=1 next cycle. Raise `busy` -> `ready`=0 at the following edge.
- **Image fetch:** in RUN, `iaddr`=12'h0A5 -> `idata`=20'h000A5 in the same cycle. `iaddr`=12'hFFF -> 20'h00FFF.
- **Bank decode:**
  - `cwr` csel=001 addr 5 data 20'h12345, then `crd` csel=001 addr 5 -> `cdata_rd`=20'h12345.
  - Same address with csel=011 -> the l1 value, not 20'h12345.
  - csel=010 write -> no memory change.
  - csel=010 read -> `cdata_rd`=0.
- **Readout:**
  - CONV writes l0[i]=i+1 and l1[j]=~j; drop `busy`.
  - Expect 4096 words with `m_layer`=0, first word 20'h00001.
  - Then 1024 words with `m_layer`=1.
  - `m_last` is high only on the word for j=1023, and `done` pulses once.
- **Backpressure:** hold `m_ready`=0 for 10 cycles mid-DUMP0 -> `m_data` is stable, there is no word loss, and the total word count is still 5120.
- **Reset mid-RUN:** assert `reset` for 1 cycle -> next cycle state is LOAD, `s_ready`=1, `ready`=0, `m_valid`=0. A new image load then proceeds normally.
